// File: rtl/thread_disp_resp.sv
// thread_disp_resp
// ----------------
// Dispatcher-side responder for the inter-CPU thread protocol. It accepts
// fork/stop requests from per-CPU thread controllers and keeps a small table
// of live threads. Each request is answered with a one-cycle DONE code. A
// scheduler pulls live threads out of the table in round-robin order.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   clk_oe        : update enable; every register holds while it is low
//   cpu_msg_in    : request code (fork / stop), single-cycle pulse
//   addr_in       : thread code address, valid with the request
//   data_in       : thread data address, valid with the request
//   cpu_msg_out   : response code (fork done / stop done) for one cycle, else 0
//   disp_online   : high only while idle; requesters send only then
//   sched_req     : scheduler asks for the next live thread
//   sched_valid   : one-cycle pulse qualifying sched_addr / sched_data
//   sched_addr    : code address of the selected entry
//   sched_data    : data address of the selected entry
//   thread_count  : number of valid table entries
//   err_full      : sticky, a fork arrived while the table was full
//   err_miss      : sticky, a stop matched no entry
//
// Configuration macro:
//   THREAD_DISP_STOP_DATA_MATCH_EN : when defined, a stop must match both the
//   code address and the data address of an entry; otherwise only the code
//   address is compared.

module thread_disp_resp #(
    parameter int DEPTH        = 8,
    parameter int IDX_W        = 3,
    parameter int CPU_MSG_SIZE = 4,
    parameter int ADDR_SIZE    = 32,
    parameter int DATA_SIZE    = 32,
    parameter logic [CPU_MSG_SIZE-1:0] CPU_R_FORK_THRD = 4'h1,
    parameter logic [CPU_MSG_SIZE-1:0] CPU_R_STOP_THRD = 4'h2,
    parameter logic [CPU_MSG_SIZE-1:0] CPU_R_FORK_DONE = 4'h3,
    parameter logic [CPU_MSG_SIZE-1:0] CPU_R_STOP_DONE = 4'h4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_oe,
    input  logic [CPU_MSG_SIZE-1:0] cpu_msg_in,
    input  logic [ADDR_SIZE-1:0]    addr_in,
    input  logic [DATA_SIZE-1:0]    data_in,
    output logic [CPU_MSG_SIZE-1:0] cpu_msg_out,
    output logic                    disp_online,
    input  logic                    sched_req,
    output logic                    sched_valid,
    output logic [ADDR_SIZE-1:0]    sched_addr,
    output logic [DATA_SIZE-1:0]    sched_data,
    output logic [IDX_W:0]          thread_count,
    output logic                    err_full,
    output logic                    err_miss
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSERT,
        ST_SEARCH,
        ST_REMOVE,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [DEPTH-1:0]        valid_q;
    logic [ADDR_SIZE-1:0]    entryAddr_q [DEPTH];
    logic [DATA_SIZE-1:0]    entryData_q [DEPTH];
    logic [ADDR_SIZE-1:0]    reqAddr_q;
    logic [DATA_SIZE-1:0]    reqData_q;
    logic [IDX_W-1:0]        scanIdx_q;
    logic [IDX_W-1:0]        rrPtr_q;
    logic [CPU_MSG_SIZE-1:0] msgOut_q;
    logic                    schedValid_q;
    logic [ADDR_SIZE-1:0]    schedAddr_q;
    logic [DATA_SIZE-1:0]    schedData_q;
    logic [IDX_W:0]          threadCount_q;
    logic                    errFull_q;
    logic                    errMiss_q;

    logic                    freeFound;
    logic [IDX_W-1:0]        freeIdx;
    logic                    schedFound;
    logic [IDX_W-1:0]        schedIdx_d;
    logic [IDX_W-1:0]        schedCand;
    logic                    scanMatch;
    logic                    isFork;
    logic                    isStop;

    assign isFork = (cpu_msg_in == CPU_R_FORK_THRD);
    assign isStop = (cpu_msg_in == CPU_R_STOP_THRD);

    // Lowest-index free entry: scanning downwards lets the lowest index win.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    // Round-robin pick: offsets DEPTH..1 scanned downwards so the smallest
    // offset from rrPtr_q wins; offset DEPTH wraps to rrPtr_q itself, which
    // is therefore considered last. DEPTH is a power of two, so the index
    // sum wraps naturally.
    always_comb begin
        schedFound = 1'b0;
        schedIdx_d = rrPtr_q;
        schedCand  = rrPtr_q;
        for (int off = DEPTH; off >= 1; off--) begin
            schedCand = rrPtr_q + IDX_W'(off);
            if (valid_q[schedCand]) begin
                schedFound = 1'b1;
                schedIdx_d = schedCand;
            end
        end
    end

`ifdef THREAD_DISP_STOP_DATA_MATCH_EN
    assign scanMatch = valid_q[scanIdx_q]
                     && (entryAddr_q[scanIdx_q] == reqAddr_q)
                     && (entryData_q[scanIdx_q] == reqData_q);
`else
    assign scanMatch = valid_q[scanIdx_q]
                     && (entryAddr_q[scanIdx_q] == reqAddr_q);
`endif

    // Dispatcher FSM, thread table and scheduler port. A request always has
    // priority over the scheduler in the idle state; the DONE code is set on
    // entry to ST_DONE so it is visible for exactly the ST_DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            valid_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr_q[i] <= '0;
                entryData_q[i] <= '0;
            end
            reqAddr_q     <= '0;
            reqData_q     <= '0;
            scanIdx_q     <= '0;
            rrPtr_q       <= IDX_W'(DEPTH - 1);
            msgOut_q      <= '0;
            schedValid_q  <= 1'b0;
            schedAddr_q   <= '0;
            schedData_q   <= '0;
            threadCount_q <= '0;
            errFull_q     <= 1'b0;
            errMiss_q     <= 1'b0;
        end else if (clk_oe) begin
            schedValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (isFork) begin
                        reqAddr_q <= addr_in;
                        reqData_q <= data_in;
                        state_q   <= ST_INSERT;
                    end else if (isStop) begin
                        reqAddr_q <= addr_in;
                        reqData_q <= data_in;
                        scanIdx_q <= '0;
                        state_q   <= ST_SEARCH;
                    end else if (sched_req && schedFound) begin
                        schedValid_q <= 1'b1;
                        schedAddr_q  <= entryAddr_q[schedIdx_d];
                        schedData_q  <= entryData_q[schedIdx_d];
                        rrPtr_q      <= schedIdx_d;
                    end
                end
                ST_INSERT: begin
                    if (freeFound) begin
                        valid_q[freeIdx]     <= 1'b1;
                        entryAddr_q[freeIdx] <= reqAddr_q;
                        entryData_q[freeIdx] <= reqData_q;
                        threadCount_q        <= threadCount_q + (IDX_W+1)'(1);
                    end else begin
                        errFull_q <= 1'b1;
                    end
                    msgOut_q <= CPU_R_FORK_DONE;
                    state_q  <= ST_DONE;
                end
                ST_SEARCH: begin
                    if (scanMatch) begin
                        state_q <= ST_REMOVE;
                    end else if (scanIdx_q == IDX_W'(DEPTH - 1)) begin
                        errMiss_q <= 1'b1;
                        msgOut_q  <= CPU_R_STOP_DONE;
                        state_q   <= ST_DONE;
                    end else begin
                        scanIdx_q <= scanIdx_q + IDX_W'(1);
                    end
                end
                ST_REMOVE: begin
                    valid_q[scanIdx_q] <= 1'b0;
                    threadCount_q      <= threadCount_q - (IDX_W+1)'(1);
                    msgOut_q           <= CPU_R_STOP_DONE;
                    state_q            <= ST_DONE;
                end
                ST_DONE: begin
                    msgOut_q <= '0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    msgOut_q <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign disp_online  = (state_q == ST_IDLE);
    assign cpu_msg_out  = msgOut_q;
    assign sched_valid  = schedValid_q;
    assign sched_addr   = schedAddr_q;
    assign sched_data   = schedData_q;
    assign thread_count = threadCount_q;
    assign err_full     = errFull_q;
    assign err_miss     = errMiss_q;

endmodule

// File: doc/thread_disp_resp.md
# thread_disp_resp

Dispatcher-side responder for the inter-CPU thread protocol. It accepts `CPU_R_FORK_THRD` and `CPU_R_STOP_THRD` requests issued by per-CPU thread controllers on `cpu_msg_in`/`addr_in`/`data_in`. It keeps a small table of live threads and answers each request with a one-cycle `CPU_R_FORK_DONE` or `CPU_R_STOP_DONE`. A scheduler pulls the next live thread from the table round-robin.

## Interface
- `DEPTH`, 8: number of thread-table entries; power of two, 2..16.
- `IDX_W`, 3: log2(`DEPTH`).

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clk_oe` in 1: update enable. When 0, every register holds.
- `cpu_msg_in` in `CPU_MSG_SIZE`: request code; single-cycle pulse from the requester.
- `addr_in` in `ADDR_SIZE`: thread code address, valid with the request.
- `data_in` in `DATA_SIZE`: thread data address, valid with the request.
- `cpu_msg_out` out `CPU_MSG_SIZE`: response code (`CPU_R_FORK_DONE` / `CPU_R_STOP_DONE`), else 0.
- `disp_online` out 1: high only in IDLE; requesters send only while it is high.
- `sched_req` in 1: scheduler asks for the next live thread.
- `sched_valid` out 1: one-cycle pulse; `sched_addr`/`sched_data` are valid with it.
- `sched_addr` out `ADDR_SIZE`: code address of the selected entry.
- `sched_data` out `DATA_SIZE`: data address of the selected entry.
- `thread_count` out `IDX_W+1`: number of valid entries.
- `err_full` out 1: sticky; set by a fork while full.
- `err_miss` out 1: sticky; set by a stop with no match.

## Operation
- Table: per entry `valid`, `addr`, `data`. Entries store `addr_in`/`data_in` exactly as received.
- FSM states: IDLE, INSERT, SEARCH, REMOVE, DONE.
- IDLE, `cpu_msg_in == CPU_R_FORK_THRD`: latch addr/data and go to INSERT.
- IDLE, `cpu_msg_in == CPU_R_STOP_THRD`: latch addr/data, clear scan index, go to SEARCH.
- IDLE, any other code: ignored.
- INSERT: write to the lowest-index free entry and set its valid bit. If the table is full, write nothing and set `err_full`. Then go to DONE with response `CPU_R_FORK_DONE`.
- SEARCH: check one entry per cycle, starting at index 0. Match = entry valid and `addr` equal.
  - On match, go to REMOVE holding that index.
  - After index `DEPTH-1` with no match, set `err_miss` and go to DONE.
  - The response is `CPU_R_STOP_DONE` in both cases.
- REMOVE: clear the valid bit. If the removed index equals the round-robin pointer, the pointer is unchanged. Go to DONE.
- DONE: `cpu_msg_out` = latched response for exactly this one cycle, then IDLE.
- Requests arriving outside IDLE are ignored. `disp_online` is low in those states, so no request is lost under a compliant requester.
- Scheduler: served only in IDLE, and only when no request is present that cycle (a request has priority).
  - Search starts at `rr_ptr+1` mod `DEPTH`, wraps, and includes `rr_ptr` last. The first valid entry found is registered to `sched_addr`/`sched_data`, `sched_valid`=1 for one cycle, and `rr_ptr` is set to that index.
  - If the table is empty, `sched_valid` stays 0.
  - A `sched_req` that is not served is dropped; the scheduler re-asserts it.
- `thread_count` is updated in the same cycle the valid bit changes.

## Timing
- Reset values: state IDLE, all valid bits 0, `rr_ptr`=`DEPTH-1`, `cpu_msg_out`=0, `disp_online`=1, `sched_valid`=0, `sched_addr`=0, `sched_data`=0, `thread_count`=0, `err_full`=0, `err_miss`=0.
- Reset mid-operation: any in-flight request is dropped with no DONE issued.
- Fork latency: request sampled at edge E0; entry written at E1; `cpu_msg_out` is the DONE code from E1 to E2; `disp_online` returns high at E2.
- Stop latency: E0 sample, then k+1 SEARCH cycles for a match at index k, one REMOVE cycle, one DONE cycle. A miss takes `DEPTH` SEARCH cycles and no REMOVE cycle.
- Scheduler latency: `sched_req` sampled at an edge; `sched_valid` is high for the following cycle.
- `clk_oe` low freezes the FSM, table, pointer and all outputs; a DONE or `sched_valid` cycle is stretched by the frozen cycles.
- `disp_online` is combinational from state (IDLE).

## Configuration
- `THREAD_DISP_STOP_DATA_MATCH_EN` defined: the SEARCH match also requires `data` equal to the latched `data_in`.
- Not defined: match on `addr` only; entry `data` is never compared.

## Test plan
- Reset, then fork addr=0x100, data=0x200: `cpu_msg_out`=`CPU_R_FORK_DONE` exactly one cycle, two cycles after the request; `thread_count`=1; `disp_online` is low for two cycles.
- Forks 0x100, 0x110, 0x120, then stop 0x110: `CPU_R_STOP_DONE` after 2 SEARCH + 1 REMOVE cycles; `thread_count`=2; a following fork 0x130 lands in index 1.
- Fill all 8 entries, then fork 0x900: DONE still returned, `err_full`=1, `thread_count`=8. Stop 0x999: `err_miss`=1 after 8 SEARCH cycles.
- Entries 0x100, 0x110, 0x120; `sched_req` four times: `sched_addr` = 0x100, 0x110, 0x120, 0x100. On an empty table, `sched_valid` stays 0.
- `sched_req` in the same cycle as a fork: the fork is served and `sched_valid` stays 0. Assert `rst` during SEARCH: all outputs return to reset values at once and no DONE appears.
- With the macro defined: entry (0x100, 0x200), stop (0x100, 0x300): `err_miss`=1 and the entry is kept. Without the macro: the entry is removed.
